checker_mem_arb: RTL and testbench

CHECKER_MEM_ARB -- requirements
Module: checker_mem_arb

---
 rtl/checker_mem_arb.sv | 156 +++++++++++++++
 tb/tb_checker_mem_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checker_mem_arb.sv
// rtl/checker_mem_arb.sv - single-port RAM arbiter between a Wishbone slave and the checker MPU
module checker_mem_arb #(
    parameter int ADDR_W   = 11,
    parameter int MAX_WAIT = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic              mpu_req,
    input  logic              mpu_we,
    input  logic [ADDR_W-1:0] mpu_adr,
    input  logic [31:0]       mpu_dat_i,
    input  logic [3:0]        mpu_sel,
    input  logic              mpu_prio,
    output logic              mpu_gnt,
    output logic              mpu_valid,
    output logic [31:0]       mpu_dat_o,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do,
    output logic              busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WB_ACC   = 3'd1;
    localparam logic [2:0] S_WB_ACK   = 3'd2;
    localparam logic [2:0] S_MPU_ACC  = 3'd3;
    localparam logic [2:0] S_MPU_DONE = 3'd4;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    // last_winner encoding: 0 = WB served last, 1 = MPU served last
    localparam logic LW_WB  = 1'b0;
    localparam logic LW_MPU = 1'b1;

    logic [2:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       r_last_winner;

    logic w_wb_req;
    logic w_idle;
    logic w_wb_busy;
    logic w_grant_wb;
    logic w_grant_mpu;
    logic w_unused;

    assign w_wb_req  = wb_cyc_i & wb_stb_i;
    assign w_idle    = (r_state == S_IDLE);
    assign w_wb_busy = (r_state == S_WB_ACC) || (r_state == S_WB_ACK);

    // Byte-lane bits and address bits above the RAM window are ignored; the window aliases.
    assign w_unused = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

    // Grant decision, only meaningful in IDLE: starvation guard, then MPU priority, then round-robin.
    always_comb begin
        w_grant_wb  = 1'b0;
        w_grant_mpu = 1'b0;
        if (w_idle) begin
            if (w_wb_req && mpu_req) begin
                if (r_wait_cnt >= WAIT_LIM) begin
                    w_grant_wb = 1'b1;
                end else if (mpu_prio) begin
                    w_grant_mpu = 1'b1;
                end else if (r_last_winner == LW_MPU) begin
                    w_grant_wb = 1'b1;
                end else begin
                    w_grant_mpu = 1'b1;
                end
            end else if (w_wb_req) begin
                w_grant_wb = 1'b1;
            end else if (mpu_req) begin
                w_grant_mpu = 1'b1;
            end
        end
    end

    // Access sequencing: every access runs through its two states and back to IDLE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_wb) begin
                        r_state <= S_WB_ACC;
                    end else if (w_grant_mpu) begin
                        r_state <= S_MPU_ACC;
                    end
                end
                S_WB_ACC:   r_state <= S_WB_ACK;
                S_WB_ACK:   r_state <= S_IDLE;
                S_MPU_ACC:  r_state <= S_MPU_DONE;
                S_MPU_DONE: r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // RAM port is loaded on the granting edge; write strobes are dropped on the following edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ram_adr <= '0;
            ram_di  <= '0;
            ram_we  <= 4'h0;
        end else if (w_grant_wb) begin
            ram_adr <= wb_adr_i[ADDR_W+1:2];
            ram_di  <= wb_dat_i;
            ram_we  <= wb_we_i ? wb_sel_i : 4'h0;
        end else if (w_grant_mpu) begin
            ram_adr <= mpu_adr;
            ram_di  <= mpu_dat_i;
            ram_we  <= mpu_we ? mpu_sel : 4'h0;
        end else begin
            ram_we  <= 4'h0;
        end
    end

    // Remember who was served so a plain tie goes to the other side next time.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_last_winner <= LW_MPU;
        end else if (w_grant_wb) begin
            r_last_winner <= LW_WB;
        end else if (w_grant_mpu) begin
            r_last_winner <= LW_MPU;
        end
    end

    // WB starvation counter: counts cycles a WB request waits while not being serviced.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wait_cnt <= 8'd0;
        end else if (!w_wb_req || w_grant_wb) begin
            r_wait_cnt <= 8'd0;
        end else if (!w_wb_busy && (r_wait_cnt < WAIT_LIM)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // A master that dropped cyc before the ack cycle gets no ack; the access still completes.
    assign wb_ack_o  = (r_state == S_WB_ACK) && wb_cyc_i;
    assign wb_dat_o  = wb_ack_o ? ram_do : 32'h0;
    assign mpu_gnt   = (r_state == S_MPU_ACC);
    assign mpu_valid = (r_state == S_MPU_DONE);
    assign mpu_dat_o = mpu_valid ? ram_do : 32'h0;
    assign busy      = !w_idle;

endmodule

// File: tb/tb_checker_mem_arb.sv
// tb/tb_checker_mem_arb.sv - self-checking bench for checker_mem_arb
module tb_checker_mem_arb;

    localparam int ADDR_W   = 11;
    localparam int MAX_WAIT = 8;
    // Each MPU access keeps WB waiting 3 cycles; MPU keeps winning until the wait reaches MAX_WAIT.
    localparam int N_MPU_FIRST = (MAX_WAIT + 2) / 3;

    logic              sys_clk;
    logic              sys_rst;
    logic [31:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_we_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              mpu_req;
    logic              mpu_we;
    logic [ADDR_W-1:0] mpu_adr;
    logic [31:0]       mpu_dat_i;
    logic [3:0]        mpu_sel;
    logic              mpu_prio;
    logic              mpu_gnt;
    logic              mpu_valid;
    logic [31:0]       mpu_dat_o;
    logic [ADDR_W-1:0] ram_adr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_di;
    logic [31:0]       ram_do;
    logic              busy;

    checker_mem_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .mpu_req(mpu_req), .mpu_we(mpu_we), .mpu_adr(mpu_adr),
        .mpu_dat_i(mpu_dat_i), .mpu_sel(mpu_sel), .mpu_prio(mpu_prio),
        .mpu_gnt(mpu_gnt), .mpu_valid(mpu_valid), .mpu_dat_o(mpu_dat_o),
        .ram_adr(ram_adr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do),
        .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous-read RAM with byte write strobes (read returns the old word).
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'h0;
    end
    always @(posedge sys_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_adr][b*8 +: 8] <= ram_di[b*8 +: 8];
        end
        ram_do <= mem[ram_adr];
    end

    typedef struct {
        bit                is_mpu;
        bit                we;
        logic [31:0]       adr;
        logic [31:0]       dat;
        logic [3:0]        sel;
        logic [ADDR_W-1:0] exp_adr;
        logic [3:0]        exp_we;
        logic [31:0]       exp_rd;
    } vec_t;

    typedef struct {
        bit          chk;
        logic [31:0] dat;
    } sb_t;

    sb_t wb_q[$];
    sb_t mpu_q[$];
    int  order_log[$];
    sb_t mon_e;
    vec_t vecs[9];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard side: pop an expectation on every ack / valid, log who completed.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (wb_ack_o) begin
                order_log.push_back(0);
                chk("wb_ack_expected", 32'(wb_q.size() != 0), 32'd1);
                if (wb_q.size() != 0) begin
                    mon_e = wb_q.pop_front();
                    if (mon_e.chk) chk("wb_rdata", wb_dat_o, mon_e.dat);
                end
            end else begin
                chk("wb_dat_idle_zero", wb_dat_o, 32'h0);
            end
            if (mpu_valid) begin
                order_log.push_back(1);
                chk("mpu_valid_expected", 32'(mpu_q.size() != 0), 32'd1);
                if (mpu_q.size() != 0) begin
                    mon_e = mpu_q.pop_front();
                    if (mon_e.chk) chk("mpu_rdata", mpu_dat_o, mon_e.dat);
                end
            end else begin
                chk("mpu_dat_idle_zero", mpu_dat_o, 32'h0);
            end
        end
    end

    // Uncontended access with fixed-latency checks; call at posedge+1 with the arbiter idle.
    task automatic run_vec(input int i, input vec_t v);
        sb_t e;
        e.chk = !v.we;
        e.dat = v.exp_rd;
        if (v.is_mpu) begin
            mpu_req = 1'b1; mpu_we = v.we; mpu_adr = v.adr[ADDR_W-1:0];
            mpu_dat_i = v.dat; mpu_sel = v.sel;
            mpu_q.push_back(e);
        end else begin
            wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we; wb_adr_i = v.adr;
            wb_dat_i = v.dat; wb_sel_i = v.sel;
            wb_q.push_back(e);
        end
        @(posedge sys_clk); #1;
        chk($sformatf("v%0d_ram_adr", i), 32'(ram_adr), 32'(v.exp_adr));
        chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(v.exp_we));
        chk($sformatf("v%0d_mpu_gnt", i), 32'(mpu_gnt), 32'(v.is_mpu));
        chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
        if (v.we) chk($sformatf("v%0d_ram_di", i), ram_di, v.dat);
        @(posedge sys_clk); #1;
        chk($sformatf("v%0d_we_one_cycle", i), 32'(ram_we), 32'h0);
        if (v.is_mpu) chk($sformatf("v%0d_valid_lat", i), 32'(mpu_valid), 32'd1);
        else          chk($sformatf("v%0d_ack_lat", i), 32'(wb_ack_o), 32'd1);
        @(posedge sys_clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        mpu_req = 1'b0; mpu_we = 1'b0;
        chk($sformatf("v%0d_back_idle", i), 32'(busy), 32'd0);
    endtask

    // Contended WB read: hold the request until acked (bounded).
    task automatic wb_go(input logic [31:0] adr);
        int n;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr; wb_sel_i = 4'hF;
        wb_q.push_back('{1'b0, 32'h0});
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!wb_ack_o && n < 64);
        chk("wb_go_ack", 32'(wb_ack_o), 32'd1);
        chk("wait_cnt_cleared", 32'(dut.r_wait_cnt), 32'd0);
        @(posedge sys_clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    // Contended MPU read: hold the request until valid (bounded).
    task automatic mpu_go(input logic [ADDR_W-1:0] adr);
        int n;
        mpu_req = 1'b1; mpu_we = 1'b0; mpu_adr = adr; mpu_sel = 4'hF;
        mpu_q.push_back('{1'b0, 32'h0});
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!mpu_valid && n < 64);
        chk("mpu_go_valid", 32'(mpu_valid), 32'd1);
        @(posedge sys_clk); #1;
        mpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp27[6];
        int exp28[N_MPU_FIRST + 2];

        sys_rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        mpu_req = 0; mpu_we = 0; mpu_adr = '0; mpu_dat_i = '0; mpu_sel = '0; mpu_prio = 0;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0004, 32'h3412_e208, 4'hF, 11'h001, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         4'hF, 11'h001, 4'h0, 32'h3412_e208};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0400, 32'hdead_beef, 4'hF, 11'h400, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         4'hF, 11'h400, 4'h0, 32'hdead_beef};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_2008, 32'ha5a5_a5a5, 4'h5, 11'h002, 4'h5, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0,         4'hF, 11'h002, 4'h0, 32'h00a5_00a5};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         4'hF, 11'h002, 4'h0, 32'h00a5_00a5};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_07ff, 32'h1234_5678, 4'hC, 11'h7ff, 4'hC, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_1ffc, 32'h0,         4'hF, 11'h7ff, 4'h0, 32'h1234_0000};
        exp27 = '{0, 1, 0, 1, 0, 1};
        for (int k = 0; k < N_MPU_FIRST; k++) exp28[k] = 1;
        exp28[N_MPU_FIRST] = 0;
        exp28[N_MPU_FIRST + 1] = 1;

        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_adr", 32'(ram_adr), 32'd0);
        chk("rst_ram_di", ram_di, 32'd0);
        chk("rst_wb_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_mpu_gnt", 32'(mpu_gnt), 32'd0);
        chk("rst_mpu_valid", 32'(mpu_valid), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Master drops cyc during the ack cycle: no ack, access still returns to IDLE.
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h4; wb_sel_i = 4'hF;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        wb_cyc_i = 0; wb_stb_i = 0;
        #1;
        chk("drop_cyc_no_ack", 32'(wb_ack_o), 32'd0);
        chk("drop_cyc_busy", 32'(busy), 32'd1);
        @(posedge sys_clk); #1;
        chk("drop_cyc_idle", 32'(busy), 32'd0);

        // Simultaneous first requests after reset alternate WB, MPU, WB, ...
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        order_log.delete();
        fork
            begin repeat (3) wb_go(32'h10); end
            begin repeat (3) mpu_go(11'h010); end
        join
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_order_%0d", k), (k < order_log.size()) ? order_log[k] : 99, exp27[k]);

        // MPU priority with held request: WB waits until the starvation limit, then wins once.
        @(posedge sys_clk); #1;
        mpu_prio = 1'b1;
        order_log.delete();
        fork
            wb_go(32'h20);
            begin repeat (N_MPU_FIRST + 1) mpu_go(11'h020); end
        join
        for (int k = 0; k < N_MPU_FIRST + 2; k++)
            chk($sformatf("prio_order_%0d", k), (k < order_log.size()) ? order_log[k] : 99, exp28[k]);
        mpu_prio = 1'b0;

        // Reset during the RAM cycle of a write aborts it with no ack and no write.
        @(posedge sys_clk); #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h10; wb_dat_i = 32'hcafe_f00d; wb_sel_i = 4'hF;
        @(posedge sys_clk); #1;
        chk("abort_we_before", 32'(ram_we), 32'hF);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("abort_we_cleared", 32'(ram_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_ack", 32'(wb_ack_o), 32'd0);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        run_vec(9,  '{1'b0, 1'b0, 32'h10, 32'h0,         4'hF, 11'h004, 4'h0, 32'h0});
        run_vec(10, '{1'b0, 1'b1, 32'h10, 32'hcafe_f00d, 4'hF, 11'h004, 4'hF, 32'h0});
        run_vec(11, '{1'b1, 1'b0, 32'h4,  32'h0,         4'hF, 11'h004, 4'h0, 32'hcafe_f00d});

        repeat (2) @(posedge sys_clk);
        #1;
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        chk("mpu_q_drained", 32'(mpu_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
